// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C transaction sequencer: queue entry layouts and FSM states.
package i2c_seq_pkg;

  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
    logic       last;
  } cmd_t;

  typedef struct packed {
    logic [7:0] data;
    logic       ack_error;
  } rsp_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACTIVE,
    FLUSH
  } state_t;

  localparam int CMD_W = $bits(cmd_t);
  localparam int RSP_W = $bits(rsp_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra wrap bit on each pointer to tell full from empty.
// A push while full is accepted only if a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Command-queue front end for the i2c_master byte engine: issues queued bytes, holds ena
// across multi-byte transactions, and collects read data / ACK status into a response FIFO.
module i2c_txn_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int CMD_DEPTH = 16,
  parameter int RSP_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_data,
  input  logic       cmd_last,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_ack_error,
  output logic       i2c_ena,
  output logic [6:0] i2c_addr,
  output logic       i2c_rw,
  output logic [7:0] i2c_data_wr,
  input  logic       i2c_busy,
  input  logic [7:0] i2c_data_rd,
  input  logic       i2c_ack_error,
  output logic       idle,
  output logic       err_sticky,
  output logic       ovf_sticky,
  output logic       unf_sticky,
  input  logic       err_clear
);

  localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
  localparam int RSP_CW = $clog2(RSP_DEPTH) + 1;

  cmd_t              cmd_in, cmd_head;
  logic              cmd_full, cmd_empty, cmd_push, cmd_pop;
  logic [CMD_CW-1:0] cmd_count;
  rsp_t              rsp_in, rsp_head;
  logic              rsp_full, rsp_empty, rsp_push;
  logic [RSP_CW-1:0] rsp_level_unused;

  state_t     state_q, state_d;
  logic       busy_q;
  logic       ena_q, ena_d;
  logic [6:0] addr_q, addr_d;
  logic       rw_q, rw_d;
  logic [7:0] data_wr_q, data_wr_d;
  logic       infl_rw_q, infl_rw_d;
  logic       infl_last_q, infl_last_d;
  logic       err_q, err_d, ovf_q, ovf_d, unf_q, unf_d;
  logic       err_set, ovf_set, unf_set;
  logic       busy_rise, busy_fall;

  assign cmd_in    = '{addr: cmd_addr, rw: cmd_rw, data: cmd_data, last: cmd_last};
  assign cmd_ready = !cmd_full;
  assign cmd_push  = cmd_valid && !cmd_full;
  assign rsp_in    = '{data: i2c_data_rd, ack_error: i2c_ack_error};
  assign busy_rise = i2c_busy && !busy_q;
  assign busy_fall = !i2c_busy && busy_q;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clock (clock),
    .reset (reset),
    .push  (cmd_push),
    .wdata (cmd_in),
    .pop   (cmd_pop),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rsp_push),
    .wdata (rsp_in),
    .pop   (rsp_ready),
    .rdata (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_level_unused)
  );

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ena_d       = ena_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    data_wr_d   = data_wr_q;
    infl_rw_d   = infl_rw_q;
    infl_last_d = infl_last_q;
    cmd_pop     = 1'b0;
    rsp_push    = 1'b0;
    err_set     = 1'b0;
    unf_set     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!cmd_empty) begin
          addr_d    = cmd_head.addr;
          rw_d      = cmd_head.rw;
          data_wr_d = cmd_head.data;
          ena_d     = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (busy_rise) begin
          cmd_pop     = 1'b1;
          infl_rw_d   = cmd_head.rw;
          infl_last_d = cmd_head.last;
          // The byte just latched is still the head, so a follow-up needs a second entry.
          if (cmd_head.last) begin
            ena_d = 1'b0;
          end else if (cmd_count < CMD_CW'(2)) begin
            ena_d   = 1'b0;
            unf_set = 1'b1;
          end
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // Head advanced on the pop in ISSUE; present it while ena is held.
        if (ena_q) begin
          addr_d    = cmd_head.addr;
          rw_d      = cmd_head.rw;
          data_wr_d = cmd_head.data;
        end
        if (busy_fall) begin
          rsp_push = infl_rw_q;
          err_set  = i2c_ack_error;
          if (i2c_ack_error && !infl_last_q && ena_q) begin
            ena_d   = 1'b0;
            state_d = FLUSH;
          end else if (ena_q) begin
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (!cmd_empty) begin
          cmd_pop = 1'b1;
          if (cmd_head.last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full-FIFO push is only a drop when no pop makes room in the same cycle.
  assign ovf_set = rsp_push && rsp_full && !rsp_ready;

  always_comb begin
    err_d = err_set || (err_q && !err_clear);
    ovf_d = ovf_set || (ovf_q && !err_clear);
    unf_d = unf_set || (unf_q && !err_clear);
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      ena_q       <= 1'b0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      data_wr_q   <= '0;
      infl_rw_q   <= 1'b0;
      infl_last_q <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= i2c_busy;
      ena_q       <= ena_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      data_wr_q   <= data_wr_d;
      infl_rw_q   <= infl_rw_d;
      infl_last_q <= infl_last_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign i2c_ena       = ena_q;
  assign i2c_addr      = addr_q;
  assign i2c_rw        = rw_q;
  assign i2c_data_wr   = data_wr_q;
  assign rsp_valid     = !rsp_empty;
  assign rsp_data      = rsp_head.data;
  assign rsp_ack_error = rsp_head.ack_error;
  assign idle          = (state_q == IDLE) && cmd_empty;
  assign err_sticky    = err_q;
  assign ovf_sticky    = ovf_q;
  assign unf_sticky    = unf_q;

endmodule
